// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: registered read data, registered full/empty
// flags, and pulse/sticky reporting of rejected push and pop requests.
module sync_fifo_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow,
  output logic              err_sticky
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;
  logic              ovf_nxt, unf_nxt;
  logic [AW:0]       count_nxt;

  // Acceptance looks only at the registered flags, never at the other request.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign ovf_nxt = push & full;
  assign unf_nxt = pop & empty;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      dout       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      count      <= count_nxt;
      full       <= (count_nxt == FULL_CNT);
      empty      <= (count_nxt == '0);
      overflow   <= ovf_nxt;
      underflow  <= unf_nxt;
      err_sticky <= err_sticky | ovf_nxt | unf_nxt;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock synchronous FIFO with registered read data and full/empty status.
- It is the design end of the push/pop/full/empty interface: it accepts push/pop requests and drives the full/empty flags that the FIFO protocol checker monitors.
- It also reports illegal requests (push when full, pop when empty) through pulse and sticky error outputs, so the bench can correlate them with checker FAIL messages.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request.
- din  in  DATA_W  write data, sampled when a push is accepted.
- pop  in  1  read request.
- dout  out  DATA_W  read data; registered.
- full  out  1  high when count == DEPTH.
- empty  out  1  high when count == 0.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a push was rejected because the FIFO was full.
- underflow  out  1  one-cycle pulse: a pop was rejected because the FIFO was empty.
- err_sticky  out  1  set by any overflow or underflow; cleared only by rst.

Behaviour:
- Reset (asynchronous assert; release takes effect at the next clk edge):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0.
  - dout = 0, overflow = underflow = err_sticky = 0.
  - Storage array contents are not reset.
- Acceptance is evaluated on the flags registered in the current cycle:
  - push_ok = push & !full.
  - pop_ok = pop & !empty.
  - Rejection does not depend on the other request in the same cycle. A push when full is rejected even if pop is also high. A pop when empty is rejected even if push is also high.
- On push_ok:
  - mem[wr_ptr] <= din.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- On pop_ok:
  - dout <= mem[rd_ptr].
  - rd_ptr increments modulo DEPTH.
  - Read latency is 1: data appears on dout on the edge that accepts the pop.
  - When no pop is accepted, dout holds its previous value.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both: unchanged.
  - neither: unchanged.
- full and empty are registered and derived from the next value of count. They change on the same edge as count; there is no combinational path from push or pop to the flags.
- Simultaneous push_ok and pop_ok (possible only when 0 < count < DEPTH):
  - Both operations occur.
  - Read and write pointers never coincide in this case, so no bypass path is needed.
- Error reporting:
  - overflow <= push & full.
  - underflow <= pop & empty.
  - Both are registered pulses, high for exactly one cycle after the offending edge.
  - err_sticky <= err_sticky | overflow_next | underflow_next.
- Rejected requests leave pointers, count, storage and dout unchanged.
- Reset asserted mid-operation:
  - All state listed above clears immediately.
  - In-flight data is discarded.
  - After release, the first push goes to entry 0.
- Invariants (the bench must check these every cycle):
  - full & empty is never 1.
  - count <= DEPTH.
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when full, where the difference is 0 and count == DEPTH.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, dout=0, all error outputs 0.
- Push 0x01..0x10 on 16 consecutive cycles (DEPTH=16) -> count increments 1..16; full=1 after the 16th edge, not before. Then pop 16 times -> dout shows 0x01..0x10 in order, each one cycle after its pop; empty=1 after the last pop.
- When full, assert push=1 with din=0xAA -> push rejected, overflow pulses for 1 cycle, err_sticky=1, count stays 16. Subsequent pops show no 0xAA.
- When empty, assert push=1 and pop=1 in the same cycle with din=0x55 -> push accepted, pop rejected, underflow pulses, count=1. The next pop returns 0x55.
- Fill 8 entries, then 40 cycles of simultaneous push/pop with incrementing data -> count stays 8, both pointers wrap at least twice, output order matches a scoreboard model, no error pulses.
- Assert rst asynchronously (off-edge) with count=5 -> count=0, empty=1 and err_sticky=0 immediately. After release, push 0x77 then pop -> dout=0x77.
